// File: rtl/load_writeback_unit.sv
// load_writeback_unit: single-outstanding load unit; issues a word-aligned read, extracts and
// extends the addressed lane, and pulses the register-file write port for one cycle.
module load_writeback_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_funct3,
    input  logic [4:0]  ld_rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rdd,
    output logic [31:0] Data,
    output logic        MemREn,
    output logic        busy,
    output logic [4:0]  busy_rd,
    output logic        ld_fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAXC = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t        state, state_nx;
    logic [1:0]    lane_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rd_q;
    logic [CW-1:0] cnt;
    logic          take, illegal, accept, expired, fault_nx;
    logic [31:0]   shifted, result;

    assign ld_ready = state == IDLE;
    assign take     = state == IDLE && ld_valid;
    assign illegal  = ld_funct3[1:0] == 2'b11 || ld_funct3 == 3'b110
                   || (ld_funct3[1:0] == 2'b01 && ld_addr[0])
                   || (ld_funct3 == 3'b010 && ld_addr[1:0] != 2'b00);
    assign accept   = take && !illegal;
    assign expired  = cnt == LAST;

    // Lane is brought down to bit 0 first, so byte and halfword extraction share one path.
    assign shifted = mem_rdata >> {lane_q, 3'b000};
    assign result  = funct3_q[1:0] == 2'b00 ? {{24{shifted[7] & ~funct3_q[2]}}, shifted[7:0]}
                   : funct3_q[1:0] == 2'b01 ? {{16{shifted[15] & ~funct3_q[2]}}, shifted[15:0]}
                   : mem_rdata;

    always_comb begin
        state_nx = state;
        fault_nx = 1'b0;
        case (state)
            IDLE: begin
                state_nx = accept ? REQ : IDLE;
                fault_nx = take && illegal;
            end
            REQ:  state_nx = mem_gnt ? WAIT : REQ;
            // A response in the expiry cycle still completes the load.
            WAIT: begin
                state_nx = mem_rvalid ? WB : expired ? IDLE : WAIT;
                fault_nx = !mem_rvalid && expired;
            end
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lane_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            rdd      <= '0;
            Data     <= '0;
            MemREn   <= 1'b0;
            busy     <= 1'b0;
            busy_rd  <= '0;
            ld_fault <= 1'b0;
        end else begin
            if (take) begin
                lane_q   <= ld_addr[1:0];
                funct3_q <= ld_funct3;
                rd_q     <= ld_rd;
                mem_addr <= {ld_addr[31:2], 2'b00};
            end
            cnt <= state != WAIT ? '0 : cnt == MAXC ? cnt : cnt + 1'b1;
            if (state == WAIT && mem_rvalid) begin
                rdd  <= rd_q;
                Data <= result;
            end
            mem_req  <= state_nx == REQ;
            busy     <= state_nx != IDLE;
            busy_rd  <= state_nx == IDLE ? 5'd0 : accept ? ld_rd : rd_q;
            MemREn   <= state_nx == WB && rd_q != 5'd0;
            ld_fault <= fault_nx;
        end
    end
endmodule

// File: doc/load_writeback_unit.md
# load_writeback_unit

Load/writeback unit for the RISC-V core. Accepts one load at a time from the execute stage and issues a word-aligned read on a request/grant/response memory port. It extracts and sign- or zero-extends the addressed byte, halfword or word, then drives the register-file write port (rdd, Data, MemREn) for exactly one cycle. It also reports the in-flight destination register so the hazard logic can stall dependent reads.

## Interface
Parameters:
- TIMEOUT, default 255: maximum number of cycles spent in WAIT before the load is abandoned with a fault.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ld_valid  in  1  execute stage presents a load.
- ld_ready  out  1  unit can accept a load; high only in IDLE.
- ld_addr  in  32  byte address of the load.
- ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_rd  in  5  destination register.
- mem_req  out  1  read request, held until granted.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.
- rdd  out  5  register-file write address.
- Data  out  32  register-file write data.
- MemREn  out  1  register-file write enable; one-cycle pulse.
- busy  out  1  a load is in flight (REQ/WAIT/WB).
- busy_rd  out  5  destination of the in-flight load; 0 when not busy.
- ld_fault  out  1  one-cycle pulse: misaligned address, illegal funct3, or timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - On ld_valid=1, latch addr, funct3 and rd.
  - If the load is legal, go to REQ.
  - If it is illegal, pulse ld_fault next cycle and stay in IDLE.
  - ld_valid=0: stay in IDLE.
- Illegal loads:
  - funct3 ∈ {011,110,111}.
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]≠00.
  - Illegal loads never assert mem_req or MemREn.
- REQ: mem_req=1 with mem_addr stable. On mem_gnt=1, go to WAIT. Otherwise hold; no timeout applies in REQ.
- WAIT:
  - mem_rvalid=1: capture the extracted result and go to WB.
  - Timeout counter reaches TIMEOUT: pulse ld_fault, go to IDLE, no write.
  - mem_rvalid outside WAIT is ignored.
- WB:
  - MemREn=1 for one cycle with rdd=latched rd and Data=result; then go to IDLE.
  - If rd=0, MemREn stays 0; the memory access is still performed.
- Extraction, with lane = addr[1:0]:
  - LB/LBU: mem_rdata[8*lane+7 : 8*lane], sign-/zero-extended to 32 bits.
  - LH/LHU: mem_rdata[16*addr[1]+15 : 16*addr[1]], sign-/zero-extended.
  - LW: the full word.
- Timeout counter: cleared on entry to WAIT, incremented each WAIT cycle, sized ⌈log2(TIMEOUT+1)⌉ bits, saturating.
- busy=1 and busy_rd=latched rd in REQ, WAIT and WB.

## Timing
- Reset (resetn=0, asynchronous):
  - State goes to IDLE.
  - mem_req=0, mem_addr=0, rdd=0, Data=0, MemREn=0, busy=0, busy_rd=0, ld_fault=0, ld_ready=1.
  - The counter and latches are cleared.
- Reset mid-operation aborts the load immediately. No MemREn, and no fault pulse is produced for the aborted load.
- Minimum latency, with accept at edge T:
  - mem_req is high in cycle T+1.
  - With mem_gnt in T+1 and mem_rvalid in T+2, MemREn is high in cycle T+3 and the register file commits at the end of T+3.
  - ld_ready is high again in cycle T+4.
- mem_gnt and mem_rvalid are sampled only in REQ and WAIT respectively. The same-cycle gnt+rvalid case is not supported; rvalid comes at least one cycle after gnt.
- ld_fault for an illegal load: high in cycle T+1 only, and ld_ready stays high throughout.
- Timeout with rvalid never arriving: ld_fault pulses in the cycle after WAIT has lasted TIMEOUT cycles. rvalid arriving in the same cycle as timeout expiry wins: the load completes normally and no fault is raised.
- All outputs are registered except ld_ready, which is decoded from state.

## Test plan
- LW addr=0x100, rd=5; gnt immediately, rvalid next cycle with rdata=0xDEADBEEF -> MemREn pulse 3 cycles after accept, rdd=5, Data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80FF_0000 -> Data=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr=0x202 -> 0x000080FF.
- LH addr=0x101 -> ld_fault pulse one cycle after accept, mem_req never asserted, MemREn never asserted; funct3=011 gives the same response.
- gnt delayed 4 cycles, then rvalid withheld with TIMEOUT=8 -> mem_req held for 4 cycles, then ld_fault pulse, no write, ld_ready returns high.
- LW with rd=0 -> memory handshake completes, MemREn stays 0; busy_rd=0 throughout.
- resetn driven low while in WAIT, then rvalid arrives -> all outputs at reset values, rvalid ignored, no MemREn, next load accepted normally.
